// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Purpose  : Round-robin arbiter sharing one single-port memory among NREQ
//            requesters, one transaction in flight, fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
    parameter int NREQ   = 2,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic            rw_q, rw_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] gnt_oh;

    // Search from rr_ptr+NREQ down to rr_ptr+1 so the nearest successor wins last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int j = NREQ; j >= 1; j--) begin
            cand = PW'((int'(rr_ptr_q) + j) % NREQ);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_oh    = NREQ'(1) << gnt_q;
    assign req_ready = (state_q == IDLE && gnt_any && !reset) ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                // mem_addr_q/mem_wdata_q double as the latched request fields.
                if (gnt_any) begin
                    state_d     = ISSUE;
                    rr_ptr_d    = gnt_idx;
                    gnt_d       = gnt_idx;
                    rw_d        = req_rw[gnt_idx];
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_rw[gnt_idx];
                    mem_addr_d  = req_addr[gnt_idx*AW +: AW];
                    mem_wdata_d = req_wdata[gnt_idx*DW +: DW];
                end
            end
            ISSUE: begin
                cnt_d = CW'(RD_LAT - 1);
                if (rw_q) begin
                    state_d     = RESP;
                    rsp_valid_d = gnt_oh;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = mem_rdata;
                    rsp_valid_d = gnt_oh;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PW'(NREQ - 1);
            gnt_q       <= '0;
            rw_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_arbiter
// Purpose  : Directed bench for mem_access_arbiter; instance 0 uses RD_LAT=1,
//            instance 1 uses RD_LAT=3, both tracked by a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst        [2];
    logic [1:0] req_valid  [2];
    logic [1:0] req_rw     [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0] req_ready  [2];
    logic [1:0] rsp_valid  [2];
    logic [7:0] rsp_rdata  [2];
    logic       mem_en     [2];
    logic       mem_we     [2];
    logic [7:0] mem_addr   [2];
    logic [7:0] mem_wdata  [2];
    logic [7:0] mem_rdata  [2];
    logic       busy       [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_access_arbiter #(
            .NREQ(2), .AW(8), .DW(8), .RD_LAT((k == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[k]),
            .req_valid (req_valid[k]),
            .req_rw    (req_rw[k]),
            .req_addr  (req_addr[k]),
            .req_wdata (req_wdata[k]),
            .req_ready (req_ready[k]),
            .rsp_valid (rsp_valid[k]),
            .rsp_rdata (rsp_rdata[k]),
            .mem_en    (mem_en[k]),
            .mem_we    (mem_we[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (mem_rdata[k]),
            .busy      (busy[k])
        );
    end

    // Memory responders: data shows up RD_LAT cycles after mem_en, 0xEE otherwise.
    logic [7:0] rmem [2][256];
    logic [2:0] pv   [2] = '{3'b000, 3'b000};
    logic [7:0] pa   [2][3];
    logic       rinit = 1'b0;

    always @(posedge clk) begin
        if (!rinit) begin
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 256; a++)
                    rmem[i][a] <= 8'(a) ^ 8'hB5;
            rinit <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++)
                if (mem_en[i] && mem_we[i]) rmem[i][mem_addr[i]] <= mem_wdata[i];
        end
        for (int i = 0; i < 2; i++) begin
            pv[i]    <= {pv[i][1:0], mem_en[i] & ~mem_we[i]};
            pa[i][0] <= mem_addr[i];
            pa[i][1] <= pa[i][0];
            pa[i][2] <= pa[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            int t;
            t = (i == 0) ? 0 : 2;
            mem_rdata[i] = 8'hEE;
            if (pv[i][t]) mem_rdata[i] = rmem[i][pa[i][t]];
        end
    end

    // Transaction-level model: cycles since accept, duration until response.
    int         m_off [2];
    int         m_dur [2];
    int         m_g   [2];
    int         m_rr  [2];
    logic       m_rw  [2];
    logic [7:0] m_addr[2], m_wdata[2], m_rdata[2], m_maddr[2], m_mwdata[2];
    logic [7:0] m_mem [2][256];

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, inst, act, exp);
        end
    endtask

    function automatic int rr_pick(input int rr, input logic [1:0] v);
        for (int j = 1; j <= 2; j++) begin
            int c;
            c = (rr + j) % 2;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset(input int i);
        m_off[i] = 0; m_dur[i] = 0; m_g[i] = 0; m_rr[i] = 1; m_rw[i] = 1'b0;
        m_addr[i] = 8'h00; m_wdata[i] = 8'h00; m_rdata[i] = 8'h00;
        m_maddr[i] = 8'h00; m_mwdata[i] = 8'h00;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] e_ready, e_rsp;
            logic       e_en, e_we;
            int         g, lat;
            lat = (i == 0) ? 1 : 3;
            if (rst[i]) begin
                check("rst_ready", i, 32'(req_ready[i]), 32'd0);
                check("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
                check("rst_rsp_rdata", i, 32'(rsp_rdata[i]), 32'd0);
                check("rst_mem_en", i, 32'(mem_en[i]), 32'd0);
                check("rst_mem_we", i, 32'(mem_we[i]), 32'd0);
                check("rst_mem_addr", i, 32'(mem_addr[i]), 32'd0);
                check("rst_mem_wdata", i, 32'(mem_wdata[i]), 32'd0);
                check("rst_busy", i, 32'(busy[i]), 32'd0);
                model_reset(i);
            end else begin
                e_ready = 2'b00; e_rsp = 2'b00; e_en = 1'b0; e_we = 1'b0; g = -1;
                if (m_off[i] == 0) begin
                    g = rr_pick(m_rr[i], req_valid[i]);
                    if (g >= 0) e_ready = 2'(1 << g);
                end else begin
                    if (m_off[i] == 1) begin
                        e_en = 1'b1; e_we = m_rw[i];
                        m_maddr[i] = m_addr[i]; m_mwdata[i] = m_wdata[i];
                    end
                    if (m_off[i] == m_dur[i]) begin
                        e_rsp = 2'(1 << m_g[i]);
                        if (!m_rw[i]) m_rdata[i] = m_mem[i][m_addr[i]];
                    end
                end
                check("req_ready", i, 32'(req_ready[i]), 32'(e_ready));
                check("busy", i, 32'(busy[i]), 32'(m_off[i] != 0));
                check("mem_en", i, 32'(mem_en[i]), 32'(e_en));
                check("mem_we", i, 32'(mem_we[i]), 32'(e_we));
                check("mem_addr", i, 32'(mem_addr[i]), 32'(m_maddr[i]));
                check("mem_wdata", i, 32'(mem_wdata[i]), 32'(m_mwdata[i]));
                check("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_rsp));
                check("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(m_rdata[i]));
                if (m_off[i] == 0) begin
                    if (g >= 0) begin
                        m_g[i]     = g;
                        m_rr[i]    = g;
                        m_rw[i]    = req_rw[i][g];
                        m_addr[i]  = req_addr[i][g*8 +: 8];
                        m_wdata[i] = req_wdata[i][g*8 +: 8];
                        m_dur[i]   = m_rw[i] ? 2 : 2 + lat;
                        m_off[i]   = 1;
                        if (m_rw[i]) m_mem[i][m_addr[i]] = m_wdata[i];
                    end
                end else if (m_off[i] == m_dur[i]) begin
                    m_off[i] = 0;
                end else begin
                    m_off[i]++;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            sample();
            adv();
        end
    endtask

    int   gseq [4];
    int   gcnt;
    int   en_cnt;
    logic found;

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            for (int a = 0; a < 256; a++) m_mem[i][a] = 8'(a) ^ 8'hB5;
            rst[i] = 1'b1; req_valid[i] = 2'b00; req_rw[i] = 2'b00;
            req_addr[i] = 16'h0000; req_wdata[i] = 16'h0000;
        end
        step(2);
        rst[0] = 1'b0; rst[1] = 1'b0;
        step(1);

        // Read by requester 0, RD_LAT=1.
        req_valid[0] = 2'b01; req_rw[0] = 2'b00; req_addr[0] = 16'h0010;
        sample(); check("t1_ready", 0, 32'(req_ready[0]), 32'h1); adv();
        req_valid[0] = 2'b00;
        sample();
        check("t1_mem_en", 0, 32'(mem_en[0]), 32'h1);
        check("t1_mem_we", 0, 32'(mem_we[0]), 32'h0);
        check("t1_mem_addr", 0, 32'(mem_addr[0]), 32'h10);
        adv();
        sample(); check("t1_rsp_early", 0, 32'(rsp_valid[0]), 32'h0); adv();
        sample();
        check("t1_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
        check("t1_rsp_rdata", 0, 32'(rsp_rdata[0]), 32'hA5);
        adv();
        step(1);

        // Write by requester 1.
        req_valid[0] = 2'b10; req_rw[0] = 2'b10; req_addr[0] = 16'h2200; req_wdata[0] = 16'h3C00;
        sample(); check("t2_ready", 0, 32'(req_ready[0]), 32'h2); adv();
        req_valid[0] = 2'b00;
        sample();
        check("t2_mem_en", 0, 32'(mem_en[0]), 32'h1);
        check("t2_mem_we", 0, 32'(mem_we[0]), 32'h1);
        check("t2_mem_addr", 0, 32'(mem_addr[0]), 32'h22);
        check("t2_mem_wdata", 0, 32'(mem_wdata[0]), 32'h3C);
        adv();
        sample();
        check("t2_rsp_valid", 0, 32'(rsp_valid[0]), 32'h2);
        check("t2_rsp_rdata", 0, 32'(rsp_rdata[0]), 32'hA5);
        adv();
        step(1);

        // Both requesters held valid: strict alternation (reads of 0x10 / 0x22).
        req_valid[0] = 2'b11; req_rw[0] = 2'b00; req_addr[0] = 16'h2210;
        gcnt = 0;
        for (int c = 0; c < 16; c++) begin
            sample();
            if (req_ready[0] != 2'b00 && gcnt < 4) begin
                gseq[gcnt] = (req_ready[0] == 2'b10) ? 1 : 0;
                gcnt++;
            end
            adv();
        end
        check("t3_grant_count", 0, 32'(gcnt), 32'd4);
        for (int j = 0; j < 4; j++) check("t3_grant_order", 0, 32'(gseq[j]), 32'(j % 2));

        // Reset while in WAIT; afterwards requester 0 must win first.
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            sample();
            if (req_ready[0] != 2'b00) found = 1'b1;
            adv();
        end
        check("t4_grant_seen", 0, 32'(found), 32'h1);
        sample(); adv();
        rst[0] = 1'b1;
        #1;
        check("t4_busy_drop", 0, 32'(busy[0]), 32'h0);
        check("t4_mem_en_drop", 0, 32'(mem_en[0]), 32'h0);
        check("t4_rsp_drop", 0, 32'(rsp_valid[0]), 32'h0);
        sample(); adv();
        rst[0] = 1'b0;
        sample(); check("t4_first_grant", 0, 32'(req_ready[0]), 32'h1); adv();
        req_valid[0] = 2'b00;
        step(6);

        // Requester 1 pulses valid while busy: no access on its behalf.
        req_valid[0] = 2'b01; req_rw[0] = 2'b00; req_addr[0] = 16'h5544;
        sample(); check("t6_ready0", 0, 32'(req_ready[0]), 32'h1); adv();
        req_valid[0] = 2'b10;
        en_cnt = 0;
        sample();
        check("t6_ready1_busy", 0, 32'(req_ready[0]), 32'h0);
        en_cnt += int'(mem_en[0]);
        adv();
        req_valid[0] = 2'b00;
        for (int c = 0; c < 5; c++) begin
            sample();
            en_cnt += int'(mem_en[0]);
            adv();
        end
        check("t6_mem_en_count", 0, 32'(en_cnt), 32'd1);

        // RD_LAT=3 read on instance 1.
        req_valid[1] = 2'b01; req_rw[1] = 2'b00; req_addr[1] = 16'h0010;
        sample(); check("t5_ready", 1, 32'(req_ready[1]), 32'h1); adv();
        req_valid[1] = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            sample();
            if (c < 5) begin
                check("t5_rsp_early", 1, 32'(rsp_valid[1]), 32'h0);
            end else begin
                check("t5_rsp_valid", 1, 32'(rsp_valid[1]), 32'h1);
                check("t5_rsp_rdata", 1, 32'(rsp_rdata[1]), 32'hA5);
            end
            adv();
        end
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
